// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Turns hazard-detection requests into per-stage pipeline-register enables
//   and bubble flushes for the 5-stage MIPS pipe. The requests are D-stage
//   stalls, taken branches, multiply/divide busy and data-memory wait.
//   A three-state FSM (RUN / MD_WAIT / MEM_WAIT) sequences the multi-cycle
//   waits. The multiply/divide wait has a timeout; when it fires, the sticky
//   flag mdTimeout is set.
//
// Parameters
//   MD_TIMEOUT   maximum number of cycles spent in MD_WAIT (>= 2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   stallReqD, branchTakenD    D-stage stall request / taken branch
//   mdStartE, mdDoneE          multdiv issue from E / multdiv result ready
//   memWaitM                   data memory not ready for the M-stage access
//   EnableF/D/E/M/W            pipeline-register enables (PC, IF/ID, ID/EX,
//                              EX/MEM, MEM/WB)
//   FlushD/E/M                 bubble insertion into IF/ID, ID/EX, EX/MEM
//   ctrlState                  00 RUN, 01 MD_WAIT, 10 MEM_WAIT
//   mdTimeout                  sticky flag: multdiv never answered
//   stallCycles, flushCount    performance counters
//
// Configuration
//   PIPE_PERF_CNT_EN defined   the counters are live and saturating.
//   PIPE_PERF_CNT_EN undefined the counter ports are tied to zero.
//
// Enable and flush outputs are combinational. They are decoded from the
// registered state and the current request inputs, so a hazard takes effect
// in the same cycle that it is raised.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallReqD,
    input  logic             branchTakenD,
    input  logic             mdStartE,
    input  logic             mdDoneE,
    input  logic             memWaitM,
    output logic             EnableF,
    output logic             EnableD,
    output logic             EnableE,
    output logic             EnableM,
    output logic             EnableW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ctrlState,
    output logic             mdTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int WCNT_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = {WCNT_W{1'b1}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MD_WAIT  = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    // en = {F, D, E, M, W}, fl = {D, E, M}
    typedef struct packed {
        logic [4:0] en;
        logic [2:0] fl;
        state_t     next;
        logic       cnt_clear;
    } decode_t;

    state_t            r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_md_timeout;

    decode_t           w_dec;
    logic              w_cnt_inc;
    logic              w_set_timeout;

    // RUN-state priority decode. MEM_WAIT reuses it when memory is ready, and
    // MD_WAIT reuses it on mdDoneE with md_start forced low.
    function automatic decode_t run_decode(
        input logic mem_wait,
        input logic md_start,
        input logic stall,
        input logic branch
    );
        decode_t d;
        d.en        = 5'b11111;
        d.fl        = 3'b000;
        d.next      = ST_RUN;
        d.cnt_clear = 1'b0;
        if (mem_wait) begin
            d.en   = 5'b00000;
            d.next = ST_MEM_WAIT;
        end else if (md_start) begin
            // Hold F/D/E; let the older instruction drain into M/W; bubble M.
            d.en        = 5'b00011;
            d.fl        = 3'b001;
            d.next      = ST_MD_WAIT;
            d.cnt_clear = 1'b1;
        end else if (stall) begin
            // A stall outranks a taken branch; the branch is re-presented later.
            d.en = 5'b00111;
            d.fl = 3'b010;
        end else if (branch) begin
            d.fl = 3'b100;
        end else begin
            d.en = 5'b11111;
        end
        return d;
    endfunction

    // Next-state / output decode from registered state and current requests.
    always_comb begin
        w_dec.en        = 5'b00000;
        w_dec.fl        = 3'b000;
        w_dec.next      = ST_RUN;
        w_dec.cnt_clear = 1'b0;
        w_cnt_inc       = 1'b0;
        w_set_timeout   = 1'b0;
        if (reset) begin
            w_dec.en = 5'b00000;
            w_dec.fl = 3'b111;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_dec = run_decode(memWaitM, mdStartE, stallReqD, branchTakenD);
                end
                ST_MEM_WAIT: begin
                    if (memWaitM) begin
                        w_dec.next = ST_MEM_WAIT;
                    end else begin
                        w_dec = run_decode(1'b0, mdStartE, stallReqD, branchTakenD);
                    end
                end
                ST_MD_WAIT: begin
                    if (mdDoneE) begin
                        w_dec = run_decode(memWaitM, 1'b0, stallReqD, branchTakenD);
                    end else begin
                        // The wait count keeps running while memory also stalls.
                        w_cnt_inc = 1'b1;
                        if (memWaitM) begin
                            w_dec.en = 5'b00000;
                            w_dec.fl = 3'b000;
                        end else begin
                            w_dec.en = 5'b00011;
                            w_dec.fl = 3'b001;
                        end
                        if (r_wait_cnt == WCNT_LAST) begin
                            w_set_timeout = 1'b1;
                            w_dec.next    = ST_RUN;
                        end else begin
                            w_dec.next    = ST_MD_WAIT;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: freeze the pipe for a cycle, then recover to RUN.
                    w_dec.en   = 5'b00000;
                    w_dec.fl   = 3'b000;
                    w_dec.next = ST_RUN;
                end
            endcase
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_wait_cnt   <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state <= w_dec.next;
            if (w_dec.cnt_clear) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc && (r_wait_cnt != WCNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WCNT_ONE;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            if (w_set_timeout) begin
                r_md_timeout <= 1'b1;
            end else begin
                r_md_timeout <= r_md_timeout;
            end
        end
    end

    assign {EnableF, EnableD, EnableE, EnableM, EnableW} = w_dec.en;
    assign {FlushD, FlushE, FlushM}                      = w_dec.fl;
    assign ctrlState                                     = r_state;
    assign mdTimeout                                     = r_md_timeout;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] PERF_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PERF_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Saturating performance counters for frozen-fetch and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_dec.en[4] && (r_stall_cycles != PERF_MAX)) begin
                r_stall_cycles <= r_stall_cycles + PERF_ONE;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if ((w_dec.fl != 3'b000) && (r_flush_count != PERF_MAX)) begin
                r_flush_count <= r_flush_count + PERF_ONE;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign stallCycles = r_stall_cycles;
    assign flushCount  = r_flush_count;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. It uses directed scenarios plus
//   randomised traffic. The randomised traffic is checked against a
//   behavioural model that classifies each cycle as one pipeline action
//   (freeze, multdiv hold, D stall, branch flush, go). The model keeps
//   plain integer counters.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TO = 8;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int M_RUN = 0, M_MD = 1, M_MEM = 2;
    localparam int A_FREEZE = 0, A_MDHOLD = 1, A_STALL = 2, A_BRANCH = 3, A_GO = 4;

    logic        clk;
    logic        reset, stallReqD, branchTakenD, mdStartE, mdDoneE, memWaitM;
    logic        EnableF, EnableD, EnableE, EnableM, EnableW;
    logic        FlushD, FlushE, FlushM;
    logic [1:0]  ctrlState;
    logic        mdTimeout;
    logic [31:0] stallCycles, flushCount;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    int          m_mode = M_RUN;
    int          m_cnt  = 0;
    bit          m_to   = 1'b0;
    int          m_sc   = 0;
    int          m_fc   = 0;
    int          n_mode, n_cnt, n_sc, n_fc;
    bit          n_to;

    // expected / observed for the most recent cycle
    logic [4:0]  exp_en, obs_en;
    logic [2:0]  exp_fl, obs_fl;
    logic [1:0]  exp_st, obs_st;
    logic        exp_to, obs_to;
    logic [31:0] exp_sc, exp_fc, obs_sc, obs_fc;

    pipe_ctrl #(.MD_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stallReqD(stallReqD), .branchTakenD(branchTakenD),
        .mdStartE(mdStartE), .mdDoneE(mdDoneE), .memWaitM(memWaitM),
        .EnableF(EnableF), .EnableD(EnableD), .EnableE(EnableE), .EnableM(EnableM),
        .EnableW(EnableW), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ctrlState(ctrlState), .mdTimeout(mdTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: decide what the pipe does this cycle and where it goes next.
    task automatic model_eval();
        int  act;
        bit  use_run;
        n_mode = m_mode; n_cnt = m_cnt; n_to = m_to; n_sc = m_sc; n_fc = m_fc;
        exp_st = 2'(m_mode);
        exp_to = m_to;
        exp_sc = PERF ? 32'(m_sc) : 32'd0;
        exp_fc = PERF ? 32'(m_fc) : 32'd0;
        if (reset) begin
            exp_en = 5'b00000; exp_fl = 3'b111;
            n_mode = M_RUN; n_cnt = 0; n_to = 1'b0; n_sc = 0; n_fc = 0;
        end else begin
            use_run = (m_mode == M_RUN) || (m_mode == M_MEM && !memWaitM) ||
                      (m_mode == M_MD && mdDoneE);
            if (use_run) begin
                n_mode = M_RUN;
                if (memWaitM) begin
                    act = A_FREEZE; n_mode = M_MEM;
                end else if (mdStartE && m_mode != M_MD) begin
                    act = A_MDHOLD; n_mode = M_MD; n_cnt = 0;
                end else if (stallReqD) act = A_STALL;
                else if (branchTakenD)  act = A_BRANCH;
                else                    act = A_GO;
            end else if (m_mode == M_MEM) begin
                act = A_FREEZE;
            end else begin
                act   = memWaitM ? A_FREEZE : A_MDHOLD;
                n_cnt = m_cnt + 1;
                if (m_cnt == TO - 1) begin
                    n_to = 1'b1; n_mode = M_RUN;
                end
            end
            case (act)
                A_FREEZE: begin exp_en = 5'b00000; exp_fl = 3'b000; end
                A_MDHOLD: begin exp_en = 5'b00011; exp_fl = 3'b001; end
                A_STALL:  begin exp_en = 5'b00111; exp_fl = 3'b010; end
                A_BRANCH: begin exp_en = 5'b11111; exp_fl = 3'b100; end
                default:  begin exp_en = 5'b11111; exp_fl = 3'b000; end
            endcase
            if (!exp_en[4])         n_sc = m_sc + 1;
            if (exp_fl != 3'b000)   n_fc = m_fc + 1;
        end
    endtask

    // Apply one cycle of inputs, sample outputs mid-cycle, advance the model after the edge.
    task automatic drive_cycle(input logic rs, input logic st, input logic br,
                               input logic ms, input logic md, input logic mw);
        reset = rs; stallReqD = st; branchTakenD = br;
        mdStartE = ms; mdDoneE = md; memWaitM = mw;
        model_eval();
        @(negedge clk);
        obs_en = {EnableF, EnableD, EnableE, EnableM, EnableW};
        obs_fl = {FlushD, FlushE, FlushM};
        obs_st = ctrlState;
        obs_to = mdTimeout;
        obs_sc = stallCycles;
        obs_fc = flushCount;
        @(posedge clk);
        #1;
        m_mode = n_mode; m_cnt = n_cnt; m_to = n_to; m_sc = n_sc; m_fc = n_fc;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_en !== 5'b00000) begin n_err++; $display("FAIL reset_en: got %b expected 00000", obs_en); end
            n_checks++;
            if (obs_fl !== 3'b111) begin n_err++; $display("FAIL reset_fl: got %b expected 111", obs_fl); end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_en !== 5'b11111) begin n_err++; $display("FAIL idle_en: got %b expected 11111", obs_en); end
        n_checks++;
        if (obs_fl !== 3'b000) begin n_err++; $display("FAIL idle_fl: got %b expected 000", obs_fl); end
        n_checks++;
        if (obs_st !== 2'b00) begin n_err++; $display("FAIL idle_state: got %b expected 00", obs_st); end
        n_checks++;
        if (obs_to !== 1'b0 || obs_sc !== 32'd0 || obs_fc !== 32'd0) begin
            n_err++; $display("FAIL idle_sticky: got to=%b sc=%0d fc=%0d expected 0/0/0", obs_to, obs_sc, obs_fc);
        end
    endtask

    task automatic test_stall_vs_branch();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_en !== 5'b00111) begin n_err++; $display("FAIL stallbr_en: got %b expected 00111", obs_en); end
        n_checks++;
        if (obs_fl !== 3'b010) begin n_err++; $display("FAIL stallbr_fl: got %b expected 010", obs_fl); end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_en !== 5'b11111) begin n_err++; $display("FAIL branch_en: got %b expected 11111", obs_en); end
        n_checks++;
        if (obs_fl !== 3'b100) begin n_err++; $display("FAIL branch_fl: got %b expected 100", obs_fl); end
    endtask

    // Multdiv: five MD_WAIT cycles with done on the fifth; counters checked afterwards.
    task automatic test_md_wait();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_en !== 5'b00011 || obs_fl !== 3'b001) begin
            n_err++; $display("FAIL md_start: got en=%b fl=%b expected 00011/001", obs_en, obs_fl);
        end
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, (c == 5) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (obs_st !== 2'b01) begin n_err++; $display("FAIL md_state c%0d: got %b expected 01", c, obs_st); end
            n_checks++;
            if (c < 5 && (obs_en[2] !== 1'b0 || obs_fl !== 3'b001)) begin
                n_err++; $display("FAIL md_hold c%0d: got en=%b fl=%b expected xx0xx/001", c, obs_en, obs_fl);
            end else if (c == 5 && (obs_en !== 5'b11111 || obs_fl !== 3'b000)) begin
                n_err++; $display("FAIL md_done: got en=%b fl=%b expected 11111/000", obs_en, obs_fl);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_st !== 2'b00) begin n_err++; $display("FAIL md_back_run: got %b expected 00", obs_st); end
        n_checks++;
        if (obs_sc !== (PERF ? 32'd5 : 32'd0)) begin
            n_err++; $display("FAIL perf_stall: got %0d expected %0d", obs_sc, PERF ? 5 : 0);
        end
        n_checks++;
        if (obs_fc !== (PERF ? 32'd5 : 32'd0)) begin
            n_err++; $display("FAIL perf_flush: got %0d expected %0d", obs_fc, PERF ? 5 : 0);
        end
    endtask

    task automatic test_md_timeout();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= TO; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_st !== 2'b01 || obs_to !== 1'b0) begin
                n_err++; $display("FAIL to_wait c%0d: got st=%b to=%b expected 01/0", c, obs_st, obs_to);
            end
        end
        for (int c = 0; c < 21; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_to !== 1'b1 || obs_st !== 2'b00) begin
                n_err++; $display("FAIL to_sticky c%0d: got to=%b st=%b expected 1/00", c, obs_to, obs_st);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_to !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b expected 0", obs_to); end
    endtask

    task automatic test_mem_wait();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_en !== 5'b00000 || obs_fl !== 3'b000) begin
                n_err++; $display("FAIL mem_freeze c%0d: got en=%b fl=%b expected 00000/000", c, obs_en, obs_fl);
            end
            n_checks++;
            if (obs_st !== ((c == 1) ? 2'b00 : 2'b10)) begin
                n_err++; $display("FAIL mem_state c%0d: got %b", c, obs_st);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_st !== 2'b10 || obs_en !== 5'b00111 || obs_fl !== 3'b010) begin
            n_err++; $display("FAIL mem_release: got st=%b en=%b fl=%b expected 10/00111/010", obs_st, obs_en, obs_fl);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_st !== 2'b00) begin n_err++; $display("FAIL mem_back_run: got %b expected 00", obs_st); end
    endtask

    task automatic test_reset_mid_wait();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_st !== 2'b00 || obs_en !== 5'b11111) begin
            n_err++; $display("FAIL reset_abandon: got st=%b en=%b expected 00/11111", obs_st, obs_en);
        end
    endtask

    // Random traffic compared cycle by cycle against the behavioural model.
    task automatic test_random();
        logic rs, st, br, ms, md, mw;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(99, 0) == 0);
            st = ($urandom_range(3, 0) == 0);
            br = ($urandom_range(3, 0) == 0);
            ms = ($urandom_range(5, 0) == 0);
            md = ($urandom_range(6, 0) == 0);
            mw = ($urandom_range(4, 0) == 0);
            drive_cycle(rs, st, br, ms, md, mw);
            n_checks++;
            if (obs_en !== exp_en || obs_fl !== exp_fl) begin
                n_err++; $display("FAIL rnd_out cyc%0d: got en=%b fl=%b expected en=%b fl=%b", i, obs_en, obs_fl, exp_en, exp_fl);
            end
            n_checks++;
            if (obs_st !== exp_st || obs_to !== exp_to) begin
                n_err++; $display("FAIL rnd_state cyc%0d: got st=%b to=%b expected st=%b to=%b", i, obs_st, obs_to, exp_st, exp_to);
            end
            n_checks++;
            if (obs_sc !== exp_sc || obs_fc !== exp_fc) begin
                n_err++; $display("FAIL rnd_perf cyc%0d: got sc=%0d fc=%0d expected sc=%0d fc=%0d", i, obs_sc, obs_fc, exp_sc, exp_fc);
            end
        end
    endtask

    initial begin
        reset = 1'b1; stallReqD = 1'b0; branchTakenD = 1'b0;
        mdStartE = 1'b0; mdDoneE = 1'b0; memWaitM = 1'b0;
        test_reset();
        test_stall_vs_branch();
        test_md_wait();
        test_md_timeout();
        test_mem_wait();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
